// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALUctrl and op-class constants for the ALU datapath
package alu_pkg;

  // ALUctrl codes understood by aluV_8
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Decoded op class
  localparam logic [1:0] OP_LS = 2'b00;
  localparam logic [1:0] OP_BR = 2'b01;
  localparam logic [1:0] OP_R  = 2'b10;
  localparam logic [1:0] OP_I  = 2'b11;

  // funct3 values the ALU supports
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - op class / funct to ALUctrl translation
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] op_type,
  input  logic [2:0] funct3,
  input  logic       f7b5,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  // Loads/stores add, branches subtract; R/I types follow funct3 and only
  // R-type uses funct7[5] to pick SUB (I-type has no SUBI).
  always_comb begin
    alu_ctrl = ALU_AND;
    illegal  = 1'b0;
    case (op_type)
      OP_LS: alu_ctrl = ALU_ADD;
      OP_BR: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          F3_ADDSUB: alu_ctrl = (op_type == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
          F3_AND:    alu_ctrl = ALU_AND;
          F3_OR:     alu_ctrl = ALU_OR;
          F3_SLT:    alu_ctrl = ALU_SLT;
          default:   illegal  = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered ALU issue stage with 2-entry skid buffer
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op_type,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             illegal_pulse,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [3:0] dec_ctrl;
  logic       dec_illegal;

  alu_ctrl_decode u_decode (
    .op_type  (in_op_type),
    .funct3   (in_funct3),
    .f7b5     (in_funct7b5),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  logic             main_valid_q, main_valid_d;
  logic [3:0]       main_ctrl_q,  main_ctrl_d;
  logic [WIDTH-1:0] main_a_q,     main_a_d;
  logic [WIDTH-1:0] main_b_q,     main_b_d;
  logic             skid_valid_q, skid_valid_d;
  logic [3:0]       skid_ctrl_q,  skid_ctrl_d;
  logic [WIDTH-1:0] skid_a_q,     skid_a_d;
  logic [WIDTH-1:0] skid_b_q,     skid_b_d;
  logic             pulse_q,      pulse_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic accept;
  logic accept_legal;
  logic accept_illegal;
  logic pop;

  // in_ready comes straight from a flop so out_ready never reaches upstream
  assign in_ready       = !skid_valid_q;
  assign accept         = in_valid && in_ready;
  assign accept_legal   = accept && !dec_illegal;
  assign accept_illegal = accept && dec_illegal;
  assign pop            = main_valid_q && out_ready;

  // Buffer next state: skid only fills on a stall and drains into main first,
  // which keeps ordering FIFO. Skid valid implies main valid.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_a_d     = main_a_q;
    main_b_d     = main_b_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_a_d     = skid_a_q;
        main_b_d     = skid_b_q;
        skid_valid_d = 1'b0;
      end else if (accept_legal) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = dec_ctrl;
        main_a_d     = in_rs1;
        main_b_d     = in_rs2;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_legal) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = dec_ctrl;
      skid_a_d     = in_rs1;
      skid_b_d     = in_rs2;
    end
  end

  // Illegal-request pulse and saturating counter
  always_comb begin
    pulse_d = accept_illegal;
    cnt_d   = cnt_q;
    if (accept_illegal && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers; reset clears everything so outputs read zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= 4'b0000;
      main_a_q     <= '0;
      main_b_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= 4'b0000;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
      pulse_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_a_q     <= main_a_d;
      main_b_q     <= main_b_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
      pulse_q      <= pulse_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid     = main_valid_q;
  assign alu_ctrl      = main_ctrl_q;
  assign alu_a         = main_a_q;
  assign alu_b         = main_b_q;
  assign illegal_pulse = pulse_q;
  assign illegal_cnt   = cnt_q;

endmodule
